// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request, response and ALU-side signals of alu_share_arbiter.
// slave is the arbiter's view; master is the requester/ALU environment's view.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int FLAGS_WIDTH  = 4
);
  logic                    req0_valid, req0_ready, req0_ext_bit_size;
  logic [OPCODE_WIDTH-1:0] req0_opcode;
  logic [FLAGS_WIDTH-1:0]  req0_flags_mask;
  logic [DATA_WIDTH-1:0]   req0_data_a, req0_data_b;
  logic                    req1_valid, req1_ready, req1_ext_bit_size;
  logic [OPCODE_WIDTH-1:0] req1_opcode;
  logic [FLAGS_WIDTH-1:0]  req1_flags_mask;
  logic [DATA_WIDTH-1:0]   req1_data_a, req1_data_b;
  logic                    resp_valid, resp_ready, resp_id, resp_error;
  logic [DATA_WIDTH-1:0]   resp_result;
  logic [FLAGS_WIDTH-1:0]  resp_flags;
  logic                    busy;
  logic                    alu_data_valid, alu_ext_bit_size, alu_result_valid;
  logic [OPCODE_WIDTH-1:0] alu_opcode;
  logic [FLAGS_WIDTH-1:0]  alu_store_flags_mask, alu_flags;
  logic [DATA_WIDTH-1:0]   alu_data_a, alu_data_b, alu_result;
  modport slave (
    input  req0_valid, req0_ext_bit_size, req0_opcode, req0_flags_mask, req0_data_a, req0_data_b,
    input  req1_valid, req1_ext_bit_size, req1_opcode, req1_flags_mask, req1_data_a, req1_data_b,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_error, resp_result, resp_flags, busy,
    input  resp_ready,
    output alu_data_valid, alu_ext_bit_size, alu_opcode, alu_store_flags_mask, alu_data_a, alu_data_b,
    input  alu_result, alu_result_valid, alu_flags
  );
  modport master (
    output req0_valid, req0_ext_bit_size, req0_opcode, req0_flags_mask, req0_data_a, req0_data_b,
    output req1_valid, req1_ext_bit_size, req1_opcode, req1_flags_mask, req1_data_a, req1_data_b,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_error, resp_result, resp_flags, busy,
    output resp_ready,
    input  alu_data_valid, alu_ext_bit_size, alu_opcode, alu_store_flags_mask, alu_data_a, alu_data_b,
    output alu_result, alu_result_valid, alu_flags
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one multi-cycle ALU between two requesters.
// Define ALU_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES (error response).
module alu_share_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_WIDTH   = 4,
  parameter int FLAGS_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                  state_q;
  logic                    last_q, id_q, resp_valid_q, resp_error_q, busy_q, alu_dv_q, alu_ext_q;
  logic [OPCODE_WIDTH-1:0] alu_op_q;
  logic [FLAGS_WIDTH-1:0]  alu_mask_q, resp_flags_q;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_b_q, resp_result_q;
  logic                    grant0, grant1;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
`endif
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("alu_share_arbiter: TIMEOUT_CYCLES must be at least 2");
  end
  // req0 wins a tie only when req1 was granted last
  assign grant0 = !reset && state_q == IDLE && bus.req0_valid && (!bus.req1_valid || last_q);
  assign grant1 = !reset && state_q == IDLE && bus.req1_valid && !grant0;
  assign bus.req0_ready           = grant0;
  assign bus.req1_ready           = grant1;
  assign bus.resp_valid           = resp_valid_q;
  assign bus.resp_id              = id_q;
  assign bus.resp_result          = resp_result_q;
  assign bus.resp_flags           = resp_flags_q;
  assign bus.resp_error           = resp_error_q;
  assign bus.busy                 = busy_q;
  assign bus.alu_data_valid       = alu_dv_q;
  assign bus.alu_opcode           = alu_op_q;
  assign bus.alu_ext_bit_size     = alu_ext_q;
  assign bus.alu_store_flags_mask = alu_mask_q;
  assign bus.alu_data_a           = alu_a_q;
  assign bus.alu_data_b           = alu_b_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      id_q          <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      busy_q        <= 1'b0;
      alu_dv_q      <= 1'b0;
      alu_op_q      <= '0;
      alu_ext_q     <= 1'b0;
      alu_mask_q    <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (grant0 || grant1) begin
          alu_op_q   <= grant1 ? bus.req1_opcode : bus.req0_opcode;
          alu_ext_q  <= grant1 ? bus.req1_ext_bit_size : bus.req0_ext_bit_size;
          alu_mask_q <= grant1 ? bus.req1_flags_mask : bus.req0_flags_mask;
          alu_a_q    <= grant1 ? bus.req1_data_a : bus.req0_data_a;
          alu_b_q    <= grant1 ? bus.req1_data_b : bus.req0_data_b;
          id_q       <= grant1;
          last_q     <= grant1;
          alu_dv_q   <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: begin
          alu_dv_q <= 1'b0;
          state_q  <= WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
          cnt_q    <= '0;
`endif
        end
        WAIT: if (bus.alu_result_valid) begin
          resp_result_q <= bus.alu_result;
          resp_flags_q  <= bus.alu_flags;
          resp_error_q  <= 1'b0;
          resp_valid_q  <= 1'b1;
          state_q       <= RESP;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          resp_result_q <= '0;
          resp_flags_q  <= '0;
          resp_error_q  <= 1'b1;
          resp_valid_q  <= 1'b1;
          state_q       <= RESP;
        end else cnt_q <= cnt_q + 1'b1;
`endif
        RESP: if (bus.resp_ready) begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter against a
// transaction-level model (round-robin choice, a+b ALU stub with programmable latency).
module tb_alu_share_arbiter;
  localparam int DW = 32, OW = 4, FW = 4;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  bit last_id;
  logic [DW-1:0] a[2], b[2];
  logic [OW-1:0] op[2];
  logic [FW-1:0] msk[2];
  logic ext[2];
  bit v[2];
  alu_share_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .FLAGS_WIDTH(FW)) bus();
  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .FLAGS_WIDTH(FW), .TIMEOUT_CYCLES(8))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] flags_of(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y};
    return {s[31:0] == 32'd0, s[31], (x[31] == y[31]) && (s[31] != x[31]), s[32]};
  endfunction
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic drive();
    bus.req0_valid = v[0]; bus.req0_opcode = op[0]; bus.req0_ext_bit_size = ext[0];
    bus.req0_flags_mask = msk[0]; bus.req0_data_a = a[0]; bus.req0_data_b = b[0];
    bus.req1_valid = v[1]; bus.req1_opcode = op[1]; bus.req1_ext_bit_size = ext[1];
    bus.req1_flags_mask = msk[1]; bus.req1_data_a = a[1]; bus.req1_data_b = b[1];
  endtask
  task automatic rnd(input int n);
    a[n] = $urandom; b[n] = $urandom; op[n] = 4'($urandom);
    ext[n] = 1'($urandom); msk[n] = 4'($urandom);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_resp"}, {bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_flags, bus.resp_error}, 0);
    chk({tag, "_busy"}, {bus.busy, bus.alu_data_valid}, 0);
    chk({tag, "_alu"}, {bus.alu_opcode, bus.alu_ext_bit_size, bus.alu_store_flags_mask,
                        bus.alu_data_a, bus.alu_data_b}, 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    next();
    next();
    chk_zero("reset");
    chk("reset_ready", {bus.req1_ready, bus.req0_ready}, 0);
    reset = 1'b0;
    last_id = 1'b1;
  endtask
  // One full operation starting in an IDLE cycle with the requests already driven.
  task automatic run_op(input int lat, input int d, input bit hold);
    int id;
    logic [DW-1:0] ea, eb;
    logic [OW-1:0] eop;
    logic [FW-1:0] emsk, ef;
    logic eext;
    #1;
    id = (v[0] && v[1]) ? int'(!last_id) : (v[1] ? 1 : 0);
    chk("grant", {bus.req1_ready, bus.req0_ready}, (id == 1) ? 2'b10 : 2'b01);
    ea = a[id]; eb = b[id]; eop = op[id]; eext = ext[id]; emsk = msk[id];
    ef = flags_of(ea, eb);
    last_id = id[0];
    next();
    if (hold) rnd(id); else v[id] = 1'b0;
    drive();
    #1;
    chk("issue_dv", bus.alu_data_valid, 1);
    chk("issue_ops", {bus.alu_opcode, bus.alu_ext_bit_size, bus.alu_store_flags_mask,
                      bus.alu_data_a, bus.alu_data_b}, {eop, eext, emsk, ea, eb});
    chk("issue_ready", {bus.req1_ready, bus.req0_ready, bus.busy}, 3'b001);
    for (int i = 1; i < lat; i++) begin
      next();
      #1;
      chk("wait_state", {bus.alu_data_valid, bus.resp_valid, bus.req1_ready, bus.req0_ready, bus.busy}, 5'b00001);
    end
    next();
    bus.alu_result_valid = 1'b1;
    bus.alu_result = ea + eb;
    bus.alu_flags = ef;
    #1;
    chk("strobe_resp", bus.resp_valid, 0);
    next();
    bus.alu_result_valid = 1'b0;
    bus.alu_result = $urandom;
    bus.alu_flags = 4'($urandom);
    for (int i = 0; i <= d; i++) begin
      if (i == d) bus.resp_ready = 1'b1;
      #1;
      chk("resp", {bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_flags, bus.resp_error},
          {1'b1, id[0], ea + eb, ef, 1'b0});
      chk("resp_quiet", {bus.req1_ready, bus.req0_ready, bus.alu_data_valid}, 0);
      if (i < d) next();
    end
    next();
    bus.resp_ready = 1'b0;
    #1;
    chk("done", {bus.resp_valid, bus.busy}, 0);
  endtask
  initial begin
    for (int n = 0; n < 2; n++) begin v[n] = 1'b0; rnd(n); end
    drive();
    bus.resp_ready = 1'b0;
    bus.alu_result_valid = 1'b0;
    bus.alu_result = '0;
    bus.alu_flags = '0;
    do_reset();
    // single request, latency 3, fixed operands
    a[0] = 32'd5; b[0] = 32'd7; op[0] = 4'h1; ext[0] = 1'b0; msk[0] = 4'hf; v[0] = 1'b1;
    drive();
    run_op(3, 0, 1'b0);
    chk("sum12_flags", flags_of(32'd5, 32'd7), 4'b0000);
    // simultaneous requests right after reset
    do_reset();
    v[0] = 1'b1; v[1] = 1'b1; rnd(0); rnd(1); drive();
    run_op(2, 0, 1'b0);
    drive();
    run_op(1, 1, 1'b0);
    // both held for six operations, then a long response back-pressure
    v[0] = 1'b1; v[1] = 1'b1; drive();
    for (int k = 0; k < 6; k++) run_op(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'b1);
    v[0] = 1'b0; v[1] = 1'b1; drive();
    run_op(2, 10, 1'b0);
    // randomized mix of request patterns
    for (int k = 0; k < 12; k++) begin
      for (int n = 0; n < 2; n++) if (!v[n] && $urandom_range(0, 1) == 1) begin v[n] = 1'b1; rnd(n); end
      if (!v[0] && !v[1]) begin v[1] = 1'b1; rnd(1); end
      drive();
      run_op(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 1'b0);
    end
    v[0] = 1'b0; v[1] = 1'b0; drive();
    // reset while waiting, with a stray completion strobe afterwards
    do_reset();
    v[0] = 1'b1; rnd(0); drive();
    #1;
    chk("rw_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    next();
    v[0] = 1'b0; drive();
    next();
    reset = 1'b1;
    next();
    reset = 1'b0;
    #1;
    chk_zero("rst_wait");
    next();
    bus.alu_result_valid = 1'b1;
    bus.alu_result = a[0] + b[0];
    bus.alu_flags = flags_of(a[0], b[0]);
    next();
    bus.alu_result_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stray_ignored", {bus.resp_valid, bus.busy}, 0);
      next();
    end
    // request held across reset is granted again
    last_id = 1'b1;
    v[1] = 1'b1; rnd(1); drive();
    next();
    reset = 1'b1;
    next();
    reset = 1'b0;
    #1;
    chk_zero("rst_issue");
    last_id = 1'b1;
    run_op(2, 0, 1'b0);
`ifdef ALU_ARB_TIMEOUT_EN
    do_reset();
    v[0] = 1'b1; rnd(0); drive();
    next();
    v[0] = 1'b0; drive();
    for (int i = 2; i < 10; i++) begin
      next();
      #1;
      chk("to_wait", bus.resp_valid, 0);
    end
    next();
    #1;
    chk("to_resp", {bus.resp_valid, bus.resp_error, bus.resp_result, bus.resp_flags}, {2'b11, 36'd0});
    bus.alu_result_valid = 1'b1;
    bus.alu_result = 32'hdead_beef;
    next();
    bus.alu_result_valid = 1'b0;
    bus.resp_ready = 1'b1;
    #1;
    chk("to_stray", {bus.resp_valid, bus.resp_error, bus.resp_result, bus.resp_flags}, {2'b11, 36'd0});
    next();
    bus.resp_ready = 1'b0;
    #1;
    chk("to_done", bus.resp_valid, 0);
    last_id = 1'b0;
    v[1] = 1'b1; rnd(1); drive();
    run_op(3, 1, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
